// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and default geometry for the mem_sync block
//
// Purpose: holds the mem_sync controller state enum and the default
// word width / address width used when the top is instantiated bare.
// Ports: none (package).
package mem_pkg;

  localparam int DW_DEFAULT = 4;
  localparam int AW_DEFAULT = 6;

  typedef enum logic {
    INIT = 1'b0,
    IDLE = 1'b1
  } state_t;

endpackage

// File: rtl/mem_sync_array.sv
// rtl/mem_sync_array.sv - single-port storage with synchronous write and registered read
//
// Purpose: 2**AW x W word array. One access per cycle; a write updates the
// array at the edge, and a read loads the read register at the edge.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (clears the read register only)
//   en     access enable
//   we     1 = write, 0 = read (when en=1)
//   addr   word address
//   wdata  write word
//   rdata  registered read word; holds its value between reads
module mem_sync_array #(
  parameter int W  = 4,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [2**AW];

  // Array contents are not reset; the controller's zero sweep initialises them.
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_sync.sv
// rtl/mem_sync.sv - memory controller with zero-sweep init, clear and optional parity
//
// Purpose: after reset (or a clr request) sweeps zeros through every word,
// then serves single-cycle write / one-cycle-latency read requests.
// Optional feature: define MEM_PARITY_EN to store an even-parity bit per word,
// add the pinj (parity inject) input and drive perr on bad reads.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   clr    synchronous request to re-initialise the array to zero
//   e      request valid
//   rw     0 = write, 1 = read
//   a      request address
//   di     write data
//   pinj   (MEM_PARITY_EN only) invert stored parity on an accepted write
//   rdy    high while requests can be accepted (IDLE)
//   d      registered read data, holds between reads
//   dv     d is fresh this cycle
//   perr   parity error on the word presented with dv
module mem_sync
  import mem_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int AW = AW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          e,
  input  logic          rw,
  input  logic [AW-1:0] a,
  input  logic [DW-1:0] di,
`ifdef MEM_PARITY_EN
  input  logic          pinj,
`endif
  output logic          rdy,
  output logic [DW-1:0] d,
  output logic          dv,
  output logic          perr
);

`ifdef MEM_PARITY_EN
  localparam int W = DW + 1;
`else
  localparam int W = DW;
`endif

  state_t        state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt;
  logic          acc;
  logic          arr_en, arr_we;
  logic [AW-1:0] arr_addr;
  logic [W-1:0]  arr_wdata, arr_rdata;
  logic [W-1:0]  wword;

`ifdef MEM_PARITY_EN
  // Parity bit sits in the MSB; XOR of the whole stored word is 0 when intact.
  assign wword = {(^di) ^ pinj, di};
`else
  assign wword = di;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rdy       = 1'b0;
    acc       = 1'b0;
    arr_en    = 1'b0;
    arr_we    = 1'b0;
    arr_addr  = a;
    arr_wdata = wword;
    case (state)
      INIT: begin
        // The sweep owns the array port; an all-zero word also has even parity.
        arr_en    = 1'b1;
        arr_we    = 1'b1;
        arr_addr  = cnt;
        arr_wdata = '0;
        if (clr) begin
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt + AW'(1);
          if (cnt == '1) begin
            state_nxt = IDLE;
          end
        end
      end
      IDLE: begin
        rdy    = 1'b1;
        acc    = e & ~clr;
        arr_en = acc;
        arr_we = ~rw;
        if (clr) begin
          state_nxt = INIT;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = INIT;
        cnt_nxt   = '0;
      end
    endcase
  end

  // dv is registered from the accept, so a clr on the following edge cannot cancel it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dv <= 1'b0;
    end else begin
      dv <= acc & rw;
    end
  end

  mem_sync_array #(
    .W (W),
    .AW(AW)
  ) u_array (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (arr_en),
    .we   (arr_we),
    .addr (arr_addr),
    .wdata(arr_wdata),
    .rdata(arr_rdata)
  );

  assign d = arr_rdata[DW-1:0];

`ifdef MEM_PARITY_EN
  assign perr = dv & (^arr_rdata);
`else
  assign perr = 1'b0;
`endif

endmodule

// File: tb/tb_mem_sync.sv
// tb/tb_mem_sync.sv - self-checking bench for mem_sync against a behavioural model
module tb_mem_sync;

  localparam int DW = 4;
  localparam int AW = 6;
  localparam int DEPTH = 64;
`ifdef MEM_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          clr = 1'b0;
  logic          e = 1'b0;
  logic          rw = 1'b0;
  logic [AW-1:0] a = '0;
  logic [DW-1:0] di = '0;
  logic          pinj = 1'b0;
  logic          rdy, dv, perr;
  logic [DW-1:0] d;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_sync #(.DW(DW), .AW(AW)) dut (
`ifdef MEM_PARITY_EN
    .pinj (pinj),
`endif
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .e    (e),
    .rw   (rw),
    .a    (a),
    .di   (di),
    .rdy  (rdy),
    .d    (d),
    .dv   (dv),
    .perr (perr)
  );

  // Behavioural model: array contents, stored parity, remaining busy cycles.
  logic [DW-1:0] m_mem [DEPTH];
  logic          m_par [DEPTH];
  int            m_busy;
  logic [DW-1:0] m_d;
  logic          m_dv, m_perr;

  task automatic model_reset();
    m_busy = DEPTH;
    m_d = '0;
    m_dv = 1'b0;
    m_perr = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i] = '0;
      m_par[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    bit take;
    take = e && (m_busy == 0) && !clr;
    m_dv = take && rw;
    m_perr = 1'b0;
    if (take && rw) begin
      m_d = m_mem[a];
      m_perr = ((^m_mem[a]) != m_par[a]);
    end
    if (take && !rw) begin
      m_mem[a] = di;
      m_par[a] = (^di) ^ (PAR_EN & pinj);
    end
    if (clr) begin
      m_busy = DEPTH;
      for (int i = 0; i < DEPTH; i++) begin
        m_mem[i] = '0;
        m_par[i] = 1'b0;
      end
    end else if (m_busy > 0) begin
      m_busy--;
    end
  endtask

  task automatic cyc(input logic ie, input logic irw, input logic [AW-1:0] ia,
                     input logic [DW-1:0] idi, input logic iclr, input logic ipinj);
    e = ie; rw = irw; a = ia; di = idi; clr = iclr; pinj = ipinj;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (rdy !== 1'b1 && n < 200) begin
      n++;
      idle();
    end
  endtask

  task automatic test_reset();
    int n;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL rst_rdy: got %b want 0", rdy); end
    checks++; if (dv !== 1'b0) begin errors++; $display("FAIL rst_dv: got %b want 0", dv); end
    checks++; if (d !== 4'h0) begin errors++; $display("FAIL rst_d: got %h want 0", d); end
    checks++; if (perr !== 1'b0) begin errors++; $display("FAIL rst_perr: got %b want 0", perr); end
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    count_busy(n);
    checks++; if (n != 64) begin errors++; $display("FAIL init_len: got %0d cycles want 64", n); end
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b1, AW'($urandom_range(0, DEPTH - 1)), '0, 1'b0, 1'b0);
      checks++; if (dv !== 1'b1 || d !== 4'h0) begin
        errors++; $display("FAIL init_zero a=%0d: got dv=%b d=%h want dv=1 d=0", a, dv, d);
      end
    end
  endtask

  task automatic test_write_read();
    cyc(1'b1, 1'b0, 6'b101010, 4'b1111, 1'b0, 1'b0);
    checks++; if (dv !== 1'b0) begin errors++; $display("FAIL wr_no_dv: got %b want 0", dv); end
    cyc(1'b1, 1'b1, 6'b101010, 4'b0000, 1'b0, 1'b0);
    checks++; if (dv !== 1'b1 || d !== 4'b1111) begin
      errors++; $display("FAIL wr_rd: got dv=%b d=%h want dv=1 d=f", dv, d);
    end
    idle();
    checks++; if (dv !== 1'b0 || d !== 4'b1111) begin
      errors++; $display("FAIL rd_hold: got dv=%b d=%h want dv=0 d=f", dv, d);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp_d [3];
    exp_d[0] = 4'h3; exp_d[1] = 4'h5; exp_d[2] = 4'h9;
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, AW'(i + 1), exp_d[i], 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, AW'(i + 1), '0, 1'b0, 1'b0);
      checks++; if (dv !== 1'b1 || d !== exp_d[i]) begin
        errors++; $display("FAIL b2b[%0d]: got dv=%b d=%h want dv=1 d=%h", i, dv, d, exp_d[i]);
      end
    end
    idle();
    checks++; if (dv !== 1'b0) begin errors++; $display("FAIL b2b_end_dv: got %b want 0", dv); end
  endtask

  task automatic test_parity();
`ifdef MEM_PARITY_EN
    cyc(1'b1, 1'b0, 6'd5, 4'hA, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 6'd5, 4'h0, 1'b0, 1'b0);
    checks++; if (dv !== 1'b1 || d !== 4'hA || perr !== 1'b1) begin
      errors++; $display("FAIL par_inj: got dv=%b d=%h perr=%b want 1 a 1", dv, d, perr);
    end
    cyc(1'b1, 1'b0, 6'd5, 4'hA, 1'b0, 1'b0);
    checks++; if (perr !== 1'b0) begin errors++; $display("FAIL par_nodv: got %b want 0", perr); end
    cyc(1'b1, 1'b1, 6'd5, 4'h0, 1'b0, 1'b0);
    checks++; if (dv !== 1'b1 || d !== 4'hA || perr !== 1'b0) begin
      errors++; $display("FAIL par_ok: got dv=%b d=%h perr=%b want 1 a 0", dv, d, perr);
    end
`else
    cyc(1'b1, 1'b0, 6'd5, 4'hA, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 6'd5, 4'h0, 1'b0, 1'b0);
    checks++; if (dv !== 1'b1 || d !== 4'hA || perr !== 1'b0) begin
      errors++; $display("FAIL par_off: got dv=%b d=%h perr=%b want 1 a 0", dv, d, perr);
    end
`endif
  endtask

  task automatic test_clr_init();
    int n;
    cyc(1'b1, 1'b0, 6'd7, 4'h5, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL clr_rdy: got %b want 0", rdy); end
    repeat (19) idle();
    cyc(1'b1, 1'b0, 6'd7, 4'hF, 1'b1, 1'b0);
    count_busy(n);
    checks++; if (n != 64) begin errors++; $display("FAIL clr_restart: got %0d busy cycles want 64", n); end
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b1, 1'b1, AW'(i), '0, 1'b0, 1'b0);
      checks++; if (dv !== 1'b1 || d !== 4'h0) begin
        errors++; $display("FAIL clr_zero a=%0d: got dv=%b d=%h want dv=1 d=0", i, dv, d);
      end
    end
  endtask

  task automatic test_clr_after_read();
    int n;
    cyc(1'b1, 1'b0, 6'd12, 4'hC, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 6'd12, 4'h0, 1'b0, 1'b0);
    checks++; if (dv !== 1'b1 || d !== 4'hC) begin
      errors++; $display("FAIL pre_clr_rd: got dv=%b d=%h want dv=1 d=c", dv, d);
    end
    cyc(1'b1, 1'b1, 6'd12, 4'h0, 1'b1, 1'b0);
    checks++; if (dv !== 1'b0 || rdy !== 1'b0) begin
      errors++; $display("FAIL clr_wins: got dv=%b rdy=%b want dv=0 rdy=0", dv, rdy);
    end
    count_busy(n);
    checks++; if (n != 64) begin errors++; $display("FAIL clr_idle_len: got %0d want 64", n); end
    cyc(1'b1, 1'b1, 6'd12, 4'h0, 1'b0, 1'b0);
    checks++; if (dv !== 1'b1 || d !== 4'h0) begin
      errors++; $display("FAIL clr_cleared: got dv=%b d=%h want dv=1 d=0", dv, d);
    end
  endtask

  task automatic test_random(input int n_cyc);
    logic [AW-1:0] ra;
    for (int i = 0; i < n_cyc; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, DEPTH - 1)) : AW'($urandom_range(0, 7));
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), ra,
          DW'($urandom_range(0, 15)), 1'($urandom_range(0, 149) == 0), 1'($urandom_range(0, 1)));
      checks++; if (rdy !== (m_busy == 0) || dv !== m_dv || d !== m_d || perr !== (m_dv & m_perr)) begin
        errors++;
        $display("FAIL rand[%0d]: got rdy=%b dv=%b d=%h perr=%b want rdy=%b dv=%b d=%h perr=%b",
                 i, rdy, dv, d, perr, (m_busy == 0), m_dv, m_d, (m_dv & m_perr));
      end
    end
  endtask

  task automatic test_reset_mid_read();
    int n;
    count_busy(n);
    cyc(1'b1, 1'b0, 6'd9, 4'h6, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 6'd9, 4'h0, 1'b0, 1'b0);
    checks++; if (dv !== 1'b1 || d !== 4'h6) begin
      errors++; $display("FAIL pre_rst_rd: got dv=%b d=%h want dv=1 d=6", dv, d);
    end
    rst_n = 1'b0;
    #1;
    checks++; if (dv !== 1'b0 || d !== 4'h0 || rdy !== 1'b0 || perr !== 1'b0) begin
      errors++; $display("FAIL async_rst: got dv=%b d=%h rdy=%b perr=%b want 0 0 0 0", dv, d, rdy, perr);
    end
    e = 1'b1; rw = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (dv !== 1'b0) begin errors++; $display("FAIL rst_hold_dv: got %b want 0", dv); end
    model_reset();
    e = 1'b0;
    rst_n = 1'b1;
    count_busy(n);
    checks++; if (n != 64) begin errors++; $display("FAIL rst_reinit: got %0d want 64", n); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_parity();
    test_clr_init();
    test_clr_after_read();
    test_random(400);
    test_reset_mid_read();
    test_random(200);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
